// File: rtl/single_port_ram_if.sv
// Access bus for single_port_ram: shared address, write enable,
// write data and registered read data.
//
// Access protocol: there is no valid/ready handshake. Every rising edge of
// clk is one access. The master holds we/addr/din stable around the edge.
// we=1 writes din to addr. we=0 reads addr. The slave answers on dout a
// fixed number of edges later and never stalls.
interface single_port_ram_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] din;
    logic [DATA_WIDTH-1:0] dout;

    // Requester side: issues accesses and consumes read data.
    modport master (
        output we,
        output addr,
        output din,
        input  dout
    );

    // Memory side: samples accesses and returns read data.
    modport slave (
        input  we,
        input  addr,
        input  din,
        output dout
    );
endinterface

// File: rtl/single_port_ram.sv
// single_port_ram: synchronous single-port RAM built from flops so that
// reset can clear every word. Reads take one clock and writes are
// write-first: the written data shows up on dout.
//
// Optional macro SPR_OUT_REG_EN adds a second output register, which is
// also cleared by reset. With it, read and write-first latency becomes
// 2 clocks. The ports do not change.
module single_port_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input logic               clk,
    input logic               rst_n,
    single_port_ram_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_q;

    // Storage array: reset clears every word; a write cycle updates one word only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (bus.we) begin
            mem[bus.addr] <= bus.din;
        end
    end

    // Read register: loads on every edge; write-first forwards din on write cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q <= '0;
        end else if (bus.we) begin
            rd_q <= bus.din;
        end else begin
            rd_q <= mem[bus.addr];
        end
    end

`ifdef SPR_OUT_REG_EN
    logic [DATA_WIDTH-1:0] out_q;

    // Output pipeline stage: delays read data by one more clock to ease output timing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
        end else begin
            out_q <= rd_q;
        end
    end

    assign bus.dout = out_q;
`else
    assign bus.dout = rd_q;
`endif
endmodule

// File: tb/tb_single_port_ram.sv
// Testbench for single_port_ram. The reference model is a plain array for
// the memory contents and a queue of per-edge access results. dout is
// expected to show the result from LAT edges earlier, or 0 after reset.
module tb_single_port_ram;
    localparam int DW = 8;
    localparam int AW = 4;
    localparam int DEPTH = 1 << AW;
`ifdef SPR_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk;
    logic rst_n;

    single_port_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    single_port_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] exp_q [$];

    // clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no end, required end of test");
        $fatal(1, "watchdog");
    end

    // model: reset clears memory and the output history
    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        exp_q.delete();
        for (int i = 0; i < LAT; i++) exp_q.push_back('0);
    endtask

    // driver: present one access, let the edge take it, update the model
    // and return the value dout should hold now (sampled 1 ns after the edge)
    task automatic do_cycle(input logic w, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, output logic [DW-1:0] exp);
        logic [DW-1:0] result;
        bus.we   = w;
        bus.addr = a;
        bus.din  = d;
        @(posedge clk);
        #1;
        if (rst_n) begin
            result = w ? d : ref_mem[a];
            if (w) ref_mem[a] = d;
            exp_q.push_back(result);
            void'(exp_q.pop_front());
        end
        exp = exp_q[0];
    endtask

    task automatic test_reset();
        logic [DW-1:0] exp;
        logic [AW-1:0] addrs [3];
        addrs[0] = 4'd0; addrs[1] = 4'd5; addrs[2] = 4'd15;
        rst_n    = 1'b0;
        bus.we   = 1'b1;
        bus.addr = 4'd5;
        bus.din  = 8'hFF;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.dout !== 8'h00) begin
            errors++;
            $display("FAIL reset_hold: dout=%h required=00", bus.dout);
        end
        #2 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            do_cycle(1'b0, addrs[i], 8'h00, exp);
            checks++;
            if (bus.dout !== exp || exp !== 8'h00) begin
                errors++;
                $display("FAIL reset_read addr=%0d: dout=%h required=%h", addrs[i], bus.dout, exp);
            end
        end
        // flush the pipeline, then read again so LAT=2 also sees every address
        for (int i = 0; i < 3; i++) begin
            do_cycle(1'b0, addrs[i], 8'h00, exp);
            checks++;
            if (bus.dout !== 8'h00) begin
                errors++;
                $display("FAIL reset_read2 addr=%0d: dout=%h required=00", addrs[i], bus.dout);
            end
        end
    endtask

    task automatic test_write_read();
        logic [DW-1:0] exp;
        logic [DW-1:0] vals [3];
        vals[0] = 8'h81; vals[1] = 8'hEA; vals[2] = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            do_cycle(1'b1, AW'(i), vals[i], exp);
            checks++;
            if (bus.dout !== exp) begin
                errors++;
                $display("FAIL write addr=%0d: dout=%h required=%h", i, bus.dout, exp);
            end
        end
        for (int i = 0; i < 3 + LAT; i++) begin
            do_cycle(1'b0, AW'(i % 3), 8'h00, exp);
            checks++;
            if (bus.dout !== exp) begin
                errors++;
                $display("FAIL read cycle=%0d: dout=%h required=%h", i, bus.dout, exp);
            end
            // the read of word k is on dout LAT-1 edges after this one
            if (i >= LAT - 1 && i - (LAT - 1) < 3) begin
                checks++;
                if (exp_q[0] !== vals[i - (LAT - 1)]) begin
                    errors++;
                    $display("FAIL read_value word=%0d: model=%h required=%h",
                             i - (LAT - 1), exp_q[0], vals[i - (LAT - 1)]);
                end
            end
        end
    endtask

    task automatic test_write_first();
        logic [DW-1:0] exp;
        do_cycle(1'b1, 4'd7, 8'h3C, exp);
        for (int i = 0; i < LAT + 1; i++) begin
            if (i > 0) do_cycle(1'b0, 4'd7, 8'h00, exp);
            checks++;
            if (bus.dout !== exp) begin
                errors++;
                $display("FAIL write_first cycle=%0d: dout=%h required=%h", i, bus.dout, exp);
            end
        end
        checks++;
        if (bus.dout !== 8'h3C) begin
            errors++;
            $display("FAIL write_first_value: dout=%h required=3c", bus.dout);
        end
    endtask

    task automatic test_overwrite();
        logic [DW-1:0] exp;
        do_cycle(1'b1, 4'd4, 8'h11, exp);
        do_cycle(1'b1, 4'd4, 8'h22, exp);
        do_cycle(1'b1, 4'd3, 8'h55, exp);
        do_cycle(1'b0, 4'd4, 8'h00, exp);
        do_cycle(1'b0, 4'd3, 8'h00, exp);
        checks++;
        if (bus.dout !== exp) begin
            errors++;
            $display("FAIL overwrite_a: dout=%h required=%h", bus.dout, exp);
        end
        do_cycle(1'b0, 4'd3, 8'h00, exp);
        checks++;
        if (bus.dout !== exp) begin
            errors++;
            $display("FAIL overwrite_b: dout=%h required=%h", bus.dout, exp);
        end
        // after the pipeline drains, dout holds word 3
        checks++;
        if (bus.dout !== 8'h55) begin
            errors++;
            $display("FAIL isolation_word3: dout=%h required=55", bus.dout);
        end
        for (int i = 0; i < LAT; i++) do_cycle(1'b0, 4'd4, 8'h00, exp);
        checks++;
        if (bus.dout !== 8'h22) begin
            errors++;
            $display("FAIL last_write_wins_word4: dout=%h required=22", bus.dout);
        end
    endtask

    task automatic test_boundary_async_reset();
        logic [DW-1:0] exp;
        do_cycle(1'b1, 4'd15, 8'hA5, exp);
        for (int i = 0; i < LAT; i++) do_cycle(1'b0, 4'd15, 8'h00, exp);
        checks++;
        if (bus.dout !== 8'hA5) begin
            errors++;
            $display("FAIL boundary_read15: dout=%h required=a5", bus.dout);
        end
        // reset pulse lands between clock edges
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.dout !== 8'h00) begin
            errors++;
            $display("FAIL async_reset_immediate: dout=%h required=00", bus.dout);
        end
        model_reset();
        #2 rst_n = 1'b1;
        for (int i = 0; i < LAT; i++) do_cycle(1'b0, 4'd15, 8'h00, exp);
        checks++;
        if (bus.dout !== 8'h00 || exp !== 8'h00) begin
            errors++;
            $display("FAIL read15_after_reset: dout=%h required=00", bus.dout);
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] exp;
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        for (int i = 0; i < 400; i++) begin
            w = 1'($urandom_range(0, 1));
            a = AW'($urandom_range(0, DEPTH - 1));
            d = DW'($urandom_range(0, 255));
            do_cycle(w, a, d, exp);
            checks++;
            if (bus.dout !== exp) begin
                errors++;
                $display("FAIL random cycle=%0d we=%0b addr=%0d: dout=%h required=%h",
                         i, w, a, bus.dout, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_write_first();
        test_overwrite();
        test_boundary_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
